// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master control stage and its datapath:
// state codes decoded by i2c_datapath, the default SCL divider and a helper
// that maps each byte-transfer state to the acknowledge slot that follows it.
package i2c_pkg;

    typedef enum logic [7:0] {
        ST_IDLE       = 8'h00,
        ST_START      = 8'h01,
        ST_ADDRESS    = 8'h02,
        ST_READ_ACK   = 8'h03,
        ST_WRITE_DATA = 8'h04,
        ST_READ_ACK2  = 8'h05,
        ST_READ_DATA  = 8'h06,
        ST_WRITE_ACK2 = 8'h07,
        ST_STOP       = 8'h08
    } state_t;

    localparam int         CLK_DIV_DEFAULT = 4;
    localparam logic [3:0] BIT_MSB         = 4'd7;

    // Acknowledge slot that follows a completed byte phase.
    function automatic state_t byte_done_next(state_t s);
        case (s)
            ST_ADDRESS:    return ST_READ_ACK;
            ST_WRITE_DATA: return ST_READ_ACK2;
            ST_READ_DATA:  return ST_WRITE_ACK2;
            default:       return ST_STOP;
        endcase
    endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Command handshake and datapath-facing bus of the I2C master control stage.
// master: the controller side; slave: whoever issues commands and observes it.
interface i2c_master_ctrl_if;
    import i2c_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic       rw;
    logic       sda_in;
    logic       scl;
    state_t     state;
    logic [3:0] count;
    logic       i2c_scl_en;
    logic       busy;
    logic       done;
    logic       nack_err;

    modport master (
        input  cmd_valid, cmd_rw, sda_in,
        output cmd_ready, rw, scl, state, count, i2c_scl_en, busy, done, nack_err
    );

    modport slave (
        output cmd_valid, cmd_rw, sda_in,
        input  cmd_ready, rw, scl, state, count, i2c_scl_en, busy, done, nack_err
    );

endinterface

// File: rtl/i2c_scl_gen.sv
// SCL generator: half-period counter, SCL toggle and one-clock edge pulses.
// While disabled SCL idles high and the counter is cleared, so the first
// falling edge lands exactly CLK_DIV clocks after enable. 'hold' parks SCL
// high (used to stretch the final high phase of the STOP period).
module i2c_scl_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic en,
    input  logic hold,
    output logic scl,
    output logic scl_rise,
    output logic scl_fall,
    output logic half_done
);
    localparam logic [9:0] LAST = 10'(CLK_DIV - 1);

    logic [9:0] cnt_reg;

    assign half_done = en && (cnt_reg == LAST);

    // Half-period counter and SCL toggle with registered edge pulses.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_reg  <= '0;
            scl      <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
        end else begin
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            if (!en) begin
                cnt_reg <= '0;
                scl     <= 1'b1;
            end else if (cnt_reg == LAST) begin
                cnt_reg <= '0;
                if (!(hold && scl)) begin
                    scl      <= ~scl;
                    scl_rise <= ~scl;
                    scl_fall <= scl;
                end
            end else begin
                cnt_reg <= cnt_reg + 10'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C master control stage: accepts single-byte read/write commands, runs
// the START/ADDRESS/ACK/DATA/ACK/STOP sequence one SCL period per bit and
// samples the slave ACK slots. State and bit count advance on the clock after
// an SCL rising edge so they are stable at every falling edge.
// STOP keeps SCL high for its last half period and returns to IDLE at the
// point where the next falling edge would have been.
// Build option: I2C_NACK_ABORT_EN -- a NACK on the address byte skips the
// data phase and goes straight to STOP.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic resetN,
    i2c_master_ctrl_if.master bus
);
    state_t     state_reg;
    logic [3:0] count_reg;
    logic       scl_en_reg;
    logic       park_reg;
    logic       rw_reg;
    logic       ready_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       nack_reg;

    logic       scl_w;
    logic       scl_rise;
    logic       scl_fall;
    logic       half_done;
    state_t     data_state;

    i2c_scl_gen #(.CLK_DIV(CLK_DIV)) u_scl_gen (
        .clk       (clk),
        .resetN    (resetN),
        .en        (scl_en_reg),
        .hold      (park_reg),
        .scl       (scl_w),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .half_done (half_done)
    );

    assign data_state     = rw_reg ? ST_READ_DATA : ST_WRITE_DATA;

    assign bus.cmd_ready  = ready_reg;
    assign bus.rw         = rw_reg;
    assign bus.scl        = scl_w;
    assign bus.state      = state_reg;
    assign bus.count      = count_reg;
    assign bus.i2c_scl_en = scl_en_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.nack_err   = nack_reg;

    // Transaction sequencer, bit counter, ACK sampling and status outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg  <= ST_IDLE;
            count_reg  <= BIT_MSB;
            scl_en_reg <= 1'b0;
            park_reg   <= 1'b0;
            rw_reg     <= 1'b0;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            nack_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        state_reg  <= ST_START;
                        count_reg  <= BIT_MSB;
                        scl_en_reg <= 1'b1;
                        ready_reg  <= 1'b0;
                        busy_reg   <= 1'b1;
                        rw_reg     <= bus.cmd_rw;
                        nack_reg   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (scl_rise) begin
                        state_reg <= ST_ADDRESS;
                        count_reg <= BIT_MSB;
                    end
                end
                ST_ADDRESS, ST_WRITE_DATA, ST_READ_DATA: begin
                    if (scl_rise) begin
                        if (count_reg == 4'd0) begin
                            state_reg <= byte_done_next(state_reg);
                            count_reg <= BIT_MSB;
                        end else begin
                            count_reg <= count_reg - 4'd1;
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        count_reg <= BIT_MSB;
                        if (bus.sda_in) begin
                            nack_reg <= 1'b1;
                        end
`ifdef I2C_NACK_ABORT_EN
                        state_reg <= bus.sda_in ? ST_STOP : data_state;
`else
                        state_reg <= data_state;
`endif
                    end
                end
                ST_READ_ACK2: begin
                    if (scl_rise) begin
                        if (bus.sda_in) begin
                            nack_reg <= 1'b1;
                        end
                        state_reg <= ST_STOP;
                    end
                end
                ST_WRITE_ACK2: begin
                    if (scl_rise) begin
                        state_reg <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (scl_fall) begin
                        park_reg <= 1'b1;
                    end
                    if (park_reg && half_done && scl_w) begin
                        state_reg  <= ST_IDLE;
                        scl_en_reg <= 1'b0;
                        park_reg   <= 1'b0;
                        ready_reg  <= 1'b1;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    count_reg  <= BIT_MSB;
                    scl_en_reg <= 1'b0;
                    park_reg   <= 1'b0;
                    ready_reg  <= 1'b1;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

endmodule
